// File: rtl/mul_div_unit.sv
// Sequential signed 32x32 Booth multiply / 32/32 restoring divide; 33-cycle latency (1 for divide by zero).
// No backpressure: start is ignored while busy, results hold in z_hi/z_lo until the next FIX.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] z_hi,
  output logic [WIDTH-1:0] z_lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t          state, state_nxt;
  logic [WIDTH:0]  acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] m;
  logic            q_1;
  logic            op_r;
  logic            a_neg;
  logic            b_neg;
  logic            dz;
  logic [CW-1:0]   cnt;

  logic            b_is_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]  booth_sum;
  logic [WIDTH:0]  div_shift, div_trial;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign b_is_zero = (b == '0);
  assign a_mag     = a[WIDTH-1] ? -a : a;
  assign b_mag     = b[WIDTH-1] ? -b : b;

  // Booth recoding of {lo[0], q_1}; hi carries one guard bit so -M never overflows.
  always_comb begin
    booth_sum = acc_hi;
    case ({acc_lo[0], q_1})
      2'b01:   booth_sum = acc_hi + {m[WIDTH-1], m};
      2'b10:   booth_sum = acc_hi - {m[WIDTH-1], m};
      default: booth_sum = acc_hi;
    endcase
  end

  assign div_shift = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, m};
  assign quo_fix   = (a_neg ^ b_neg) ? -acc_lo : acc_lo;
  assign rem_fix   = a_neg ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (!clear) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = !op ? MUL : (b_is_zero ? FIX : DIV);
      MUL:  if (cnt == CNT_LAST) state_nxt = FIX;
      DIV:  if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (!clear) begin
      acc_hi   <= '0;
      acc_lo   <= '0;
      m        <= '0;
      q_1      <= 1'b0;
      op_r     <= 1'b0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      dz       <= 1'b0;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      z_hi     <= '0;
      z_lo     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r     <= op;
          a_neg    <= a[WIDTH-1];
          b_neg    <= b[WIDTH-1];
          dz       <= op && b_is_zero;
          div_zero <= 1'b0;
          cnt      <= '0;
          q_1      <= 1'b0;
          acc_hi   <= '0;
          m        <= op ? b_mag : b;
          // Divide by zero keeps the raw dividend in acc_lo for z_hi.
          acc_lo   <= (op && !b_is_zero) ? a_mag : a;
        end
        MUL: begin
          acc_hi <= {booth_sum[WIDTH], booth_sum[WIDTH:1]};
          acc_lo <= {booth_sum[0], acc_lo[WIDTH-1:1]};
          q_1    <= acc_lo[0];
          cnt    <= cnt + 1'b1;
        end
        DIV: begin
          if (!div_trial[WIDTH]) begin
            acc_hi <= div_trial;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end else begin
            acc_hi <= div_shift;
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          done <= 1'b1;
          if (dz) begin
            z_lo     <= '1;
            z_hi     <= acc_lo;
            div_zero <= 1'b1;
          end else if (op_r) begin
            z_lo <= quo_fix;
            z_hi <= rem_fix;
          end else begin
            z_lo <= acc_lo;
            z_hi <= acc_hi[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
